io_accum_reg: RTL and testbench
===============================

IO_ACCUM_REG -- requirements
Module: io_accum_reg

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data-path width in bits (WIDTH >= 2).
REQ-002 Parameter OFFSET, default 4'b1100 (zero-extended to WIDTH), SHALL set the constant operand.
REQ-003 Parameter SATURATE, default 0, SHALL select unsigned saturation (1) or modulo wrap (0) on result overflow or underflow.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-005 clr  input  1  SHALL be the reset: synchronous, active-low.
REQ-006 T  input  WIDTH  SHALL carry the data word sampled by ld.
REQ-007 ld  input  1  SHALL load T into the input register.
REQ-008 st  input  1  SHALL start one operation, with the result committed to K.
REQ-009 mode  input  2  SHALL select the operation: 00 ADD_OFS, 01 ACC, 10 SUB_OFS, 11 PASS.
REQ-010 K  output  WIDTH  SHALL be the registered result.
REQ-011 cout  output  1  SHALL be the registered carry/borrow from the last committed operation.
REQ-012 ovf  output  1  SHALL be the registered overflow/underflow flag from the last committed operation.
REQ-013 done  output  1  SHALL be a one-cycle pulse when a result has been committed.

Function
REQ-014 Input register Q SHALL take T at an edge where ld=1, and SHALL hold otherwise.
REQ-015 Operations SHALL be:
- ADD_OFS: R = Q + OFFSET
- ACC: R = K + Q
- SUB_OFS: R = Q - OFFSET
- PASS: R = Q
REQ-016 Arithmetic SHALL be computed at WIDTH+1 bits; cout SHALL be bit WIDTH of the sum, or the borrow for SUB_OFS.
REQ-017 ovf SHALL be 1 when cout=1 in ADD_OFS, ACC or SUB_OFS, and SHALL be 0 for PASS.
REQ-018 With SATURATE=0, K SHALL take R[WIDTH-1:0].
REQ-019 With SATURATE=1, on ovf, K SHALL take all-ones for an add and zero for a subtract.
REQ-020 At an edge where st=1, K, cout and ovf SHALL update, so the result is visible one cycle after st is sampled (latency 1).
REQ-021 done SHALL be 1 for exactly the cycle following each edge where st=1; back-to-back st SHALL give done high continuously.
REQ-022 K, cout and ovf SHALL hold their values at edges where st=0.
REQ-023 When ld and st are both 1 at the same edge, the operation SHALL use the old Q, and Q SHALL then take T.
REQ-024 ACC SHALL use K as it was before the edge, so repeated st accumulates once per cycle.
REQ-025 mode SHALL be sampled only at edges where st=1; mode changes between operations SHALL have no other effect.

Reset
REQ-026 At an edge where clr=0, Q, K, cout, ovf and done SHALL all become 0, overriding ld and st at that edge.
REQ-027 Reset asserted in the cycle after st SHALL suppress nothing already committed, but SHALL clear all state at that edge; done SHALL be 0 after reset.
REQ-028 No output SHALL change except on a rising edge of clk.

Structure
REQ-029 Package io_accum_pkg SHALL hold the mode_t enum (ADD_OFS, ACC, SUB_OFS, PASS) and the default WIDTH/OFFSET localparams.
REQ-030 The adder SHALL be the single sub-module rca_n: a WIDTH-parametrised ripple-carry adder with C_in.
REQ-031 Subtraction SHALL reuse rca_n by inverting the operand with C_in=1.

Verification (WIDTH=4, OFFSET=12)
REQ-032 Scenario 1: clr=0 for 1 edge -> K=0, cout=0, ovf=0, done=0.
REQ-033 Scenario 2: SATURATE=0; ld T=0101, then st with ADD_OFS -> K=0001, cout=1, ovf=1, done pulses once.
REQ-034 Scenario 3: SATURATE=1; same stimulus as scenario 2 -> K=1111, ovf=1. Then SUB_OFS with Q=0011 -> K=0000, ovf=1.
REQ-035 Scenario 4: ACC from K=0; ld T=0011, then st held for 3 cycles -> K = 3, 6, 9; done high for 3 cycles; ovf=0.
REQ-036 Scenario 5: Q=0010 and T=0111; ld=st=1 with PASS -> K=0010, Q=0111. Next st with PASS -> K=0111.
REQ-037 Scenario 6: st with ADD_OFS, then clr=0 on the next edge -> all outputs 0; a later st with no ld -> K=1100, because Q=0.

Source files
------------

// File: rtl/io_accum_pkg.sv
// Shared types and defaults for the io_accum_reg datapath.
// Holds the operation encoding and the default width/offset.
package io_accum_pkg;

   typedef enum logic [1:0] {
      ADD_OFS = 2'b00,
      ACC     = 2'b01,
      SUB_OFS = 2'b10,
      PASS    = 2'b11
   } mode_t;

   localparam int unsigned DEF_WIDTH  = 4;
   localparam int unsigned DEF_OFFSET = 4'b1100;

endpackage

// File: rtl/io_accum_reg_rca_n.sv
// N-bit ripple-carry adder with carry-in.
// Shared by add, accumulate and subtract paths.
module rca_n #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         co
);

   logic [N:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[N];

endmodule

// File: rtl/io_accum_reg.sv
// Registered accumulator with constant offset add/subtract,
// optional unsigned saturation and a one-cycle done pulse.
module io_accum_reg
   import io_accum_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned OFFSET   = DEF_OFFSET,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] T,
   input  logic             ld,
   input  logic             st,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] K,
   output logic             cout,
   output logic             ovf,
   output logic             done
);

   localparam logic [WIDTH-1:0] OFS = WIDTH'(OFFSET);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_cin;
   logic [WIDTH-1:0] sum;
   logic             sum_co;
   logic [WIDTH-1:0] k_nxt;
   logic             c_nxt;
   logic             v_nxt;
   logic             is_sub;

   rca_n #(.N(WIDTH)) u_rca (
      .a   (op_a),
      .b   (op_b),
      .cin (op_cin),
      .s   (sum),
      .co  (sum_co)
   );

   always_comb begin
      op_a   = q;
      op_b   = '0;
      op_cin = 1'b0;
      is_sub = 1'b0;
      c_nxt  = 1'b0;
      v_nxt  = 1'b0;
      unique case (mode_t'(mode))
         ADD_OFS: begin
            op_b  = OFS;
            c_nxt = sum_co;
            v_nxt = sum_co;
         end
         ACC: begin
            op_a  = K;
            op_b  = q;
            c_nxt = sum_co;
            v_nxt = sum_co;
         end
         SUB_OFS: begin
            // q - OFS as q + ~OFS + 1; no carry out means borrow
            op_b   = ~OFS;
            op_cin = 1'b1;
            is_sub = 1'b1;
            c_nxt  = ~sum_co;
            v_nxt  = ~sum_co;
         end
         PASS: begin
            op_b = '0;
         end
      endcase
      k_nxt = sum;
      if (SATURATE && v_nxt) begin
         k_nxt = is_sub ? '0 : '1;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         q    <= '0;
         K    <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= st;
         if (ld) begin
            q <= T;
         end
         if (st) begin
            K    <= k_nxt;
            cout <= c_nxt;
            ovf  <= v_nxt;
         end
      end
   end

endmodule

// File: tb/tb_io_accum_reg.sv
// Directed bench for io_accum_reg, wrap and saturate variants
// driven side by side from shared inputs.
module tb_io_accum_reg;

   logic       clk;
   logic       clr;
   logic [3:0] T;
   logic       ld;
   logic       st;
   logic [1:0] mode;

   logic [3:0] k0, k1;
   logic       c0, c1;
   logic       v0, v1;
   logic       d0, d1;

   int checks;
   int errors;

   io_accum_reg #(.WIDTH(4), .OFFSET(12), .SATURATE(1'b0)) u_wrap (
      .clk (clk), .clr (clr), .T (T), .ld (ld), .st (st),
      .mode (mode), .K (k0), .cout (c0), .ovf (v0), .done (d0)
   );

   io_accum_reg #(.WIDTH(4), .OFFSET(12), .SATURATE(1'b1)) u_sat (
      .clk (clk), .clr (clr), .T (T), .ld (ld), .st (st),
      .mode (mode), .K (k1), .cout (c1), .ovf (v1), .done (d1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clr = 1'b0; T = '0; ld = 1'b0; st = 1'b0; mode = 2'b00;
      #2;
      step();
      chk("rst_k0", 32'(k0), 0);
      chk("rst_c0", 32'(c0), 0);
      chk("rst_v0", 32'(v0), 0);
      chk("rst_d0", 32'(d0), 0);
      chk("rst_k1", 32'(k1), 0);

      // ADD_OFS: 5 + 12 = 17
      clr = 1'b1; ld = 1'b1; T = 4'b0101;
      step();
      ld = 1'b0; st = 1'b1; mode = 2'b00;
      step();
      chk("add_k0", 32'(k0), 1);
      chk("add_c0", 32'(c0), 1);
      chk("add_v0", 32'(v0), 1);
      chk("add_d0", 32'(d0), 1);
      chk("add_k1", 32'(k1), 15);
      chk("add_v1", 32'(v1), 1);
      st = 1'b0;
      step();
      chk("add_done_off", 32'(d0), 0);
      chk("add_hold_k0", 32'(k0), 1);

      // SUB_OFS: 3 - 12 borrows
      ld = 1'b1; T = 4'b0011;
      step();
      ld = 1'b0; st = 1'b1; mode = 2'b10;
      step();
      chk("sub_k1", 32'(k1), 0);
      chk("sub_v1", 32'(v1), 1);
      chk("sub_c1", 32'(c1), 1);
      chk("sub_k0", 32'(k0), 7);
      chk("sub_v0", 32'(v0), 1);
      st = 1'b0;

      // ACC from zero
      clr = 1'b0;
      step();
      clr = 1'b1; ld = 1'b1; T = 4'b0011;
      step();
      ld = 1'b0; st = 1'b1; mode = 2'b01;
      step();
      chk("acc1_k0", 32'(k0), 3);
      chk("acc1_d0", 32'(d0), 1);
      step();
      chk("acc2_k0", 32'(k0), 6);
      chk("acc2_d0", 32'(d0), 1);
      step();
      chk("acc3_k0", 32'(k0), 9);
      chk("acc3_d0", 32'(d0), 1);
      chk("acc3_v0", 32'(v0), 0);
      st = 1'b0;
      step();
      chk("acc_done_off", 32'(d0), 0);

      // PASS with simultaneous ld and st
      ld = 1'b1; T = 4'b0010;
      step();
      T = 4'b0111; st = 1'b1; mode = 2'b11;
      step();
      chk("pass1_k0", 32'(k0), 2);
      chk("pass1_c0", 32'(c0), 0);
      ld = 1'b0;
      step();
      chk("pass2_k0", 32'(k0), 7);
      chk("pass2_v0", 32'(v0), 0);

      // ADD_OFS then reset overriding ld
      mode = 2'b00;
      step();
      chk("pre_rst_k0", 32'(k0), 3);
      chk("pre_rst_c0", 32'(c0), 1);
      chk("pre_rst_k1", 32'(k1), 15);
      st = 1'b0; clr = 1'b0; ld = 1'b1; T = 4'b1001;
      step();
      chk("post_rst_k0", 32'(k0), 0);
      chk("post_rst_c0", 32'(c0), 0);
      chk("post_rst_v0", 32'(v0), 0);
      chk("post_rst_d0", 32'(d0), 0);
      chk("post_rst_k1", 32'(k1), 0);
      clr = 1'b1; ld = 1'b0; st = 1'b1; mode = 2'b00;
      step();
      chk("q0_add_k0", 32'(k0), 12);
      chk("q0_add_c0", 32'(c0), 0);
      chk("q0_add_k1", 32'(k1), 12);
      chk("q0_add_d0", 32'(d0), 1);

      // mode change without st has no effect
      st = 1'b0; mode = 2'b10;
      step();
      step();
      chk("mode_idle_k0", 32'(k0), 12);
      chk("mode_idle_d0", 32'(d0), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
